// File: rtl/trigger_capture_pkg.sv
// Shared types and constants for the trigger/capture write-side stage.
package trigger_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreFill,
    StWaitTrig,
    StPostFill,
    StDone
  } state_e;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/trig_detect.sv
// Level-crossing detector: remembers the previous accepted sample and flags a crossing
// between it and the current sample.
module trig_detect
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic                  slope_i,
  output logic                  trig_hit_o
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear_i) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (accept_i) begin
      prev_q       <= sample_i;
      prev_valid_q <= 1'b1;
    end
  end

  // A sample equal to the level only counts as the second half of a crossing pair.
  always_comb begin
    trig_hit_o = 1'b0;
    if (prev_valid_q) begin
      if (slope_i == SLOPE_RISING) begin
        trig_hit_o = (prev_q < level_i) && (sample_i >= level_i);
      end else begin
        trig_hit_o = (prev_q > level_i) && (sample_i <= level_i);
      end
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Write side of the sample FIFO RAM: captures a pre/post-trigger record into a circular
// buffer and reports where the trigger and the oldest sample landed.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] trig_level_i,
  input  logic                  trig_slope_i,
  input  logic [ADDR_WIDTH-1:0] pre_trig_i,
  output logic                  w_clk_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic [ADDR_WIDTH-1:0] trig_addr_o,
  output logic [ADDR_WIDTH-1:0] start_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  slope_q, slope_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic                  capturing;
  logic                  accept;
  logic                  arm_ok;
  logic                  trig_hit;
  logic [ADDR_WIDTH-1:0] pre_clamped;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [ADDR_WIDTH-1:0] ptr_inc;

  trig_detect #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig_detect (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (arm_ok),
    .accept_i  (accept),
    .sample_i  (sample_i),
    .level_i   (level_q),
    .slope_i   (slope_q),
    .trig_hit_o(trig_hit)
  );

  always_comb begin
    capturing   = (state_q == StPreFill) || (state_q == StWaitTrig) || (state_q == StPostFill);
    // An abort cancels the sample presented alongside it.
    accept      = capturing && sample_valid_i && !abort_i;
    arm_ok      = arm_i && !abort_i && ((state_q == StIdle) || (state_q == StDone));
    pre_clamped = (32'(pre_trig_i) > MEM_SIZE - 1) ? ADDR_WIDTH'(MEM_SIZE - 1) : pre_trig_i;
    cnt_inc     = cnt_q + ADDR_WIDTH'(1);
    ptr_inc     = wr_ptr_q + ADDR_WIDTH'(1);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    post_d       = post_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    level_d      = level_q;
    slope_d      = slope_q;
    w_en_d       = accept;
    w_addr_d     = accept ? wr_ptr_q : w_addr_q;
    w_data_d     = accept ? sample_i : w_data_q;

    if (accept) begin
      wr_ptr_d = ptr_inc;
    end

    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_ok) begin
            pre_d    = pre_clamped;
            post_d   = ADDR_WIDTH'(MEM_SIZE - 1) - pre_clamped;
            level_d  = trig_level_i;
            slope_d  = trig_slope_i;
            wr_ptr_d = '0;
            cnt_d    = '0;
            state_d  = (pre_clamped != '0) ? StPreFill : StWaitTrig;
          end
        end
        StPreFill: begin
          if (accept) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) begin
              state_d = StWaitTrig;
            end
          end
        end
        StWaitTrig: begin
          if (accept && trig_hit) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = '0;
            if (post_q != '0) begin
              state_d = StPostFill;
            end else begin
              state_d      = StDone;
              start_addr_d = ptr_inc;
            end
          end
        end
        StPostFill: begin
          if (accept) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) begin
              state_d      = StDone;
              start_addr_d = ptr_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      level_q      <= '0;
      slope_q      <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  always_comb begin
    w_clk_en_o   = w_en_q;
    w_addr_o     = w_addr_q;
    w_data_o     = w_data_q;
    trig_addr_o  = trig_addr_q;
    start_addr_o = start_addr_q;
    busy_o       = capturing;
    done_o       = (state_q == StDone);
  end

endmodule
